// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, programmable wait states,
// word array with byte-lane stores and an error response for bad addresses.
module dmem_responder #(
  parameter int          DEPTH       = 100,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_CODE    = 32'h0000DEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          accept;
  logic          enter_resp;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic [29:0]   acc_idx;
  logic          acc_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rword;
  logic [31:0]   mem_wword;
  logic          mem_we;

  // Zero at time 0 only; deliberately outside the reset domain.
  logic [31:0] mem [DEPTH] = '{default: '0};

  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access must be decoded from the live request rather than the captured copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_idx   = acc_addr[31:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_idx} >= DEPTH_W);
    mem_addr  = acc_idx[AW-1:0];
    mem_rword = mem[mem_addr];
    for (int unsigned i = 0; i < 4; i++) begin
      mem_wword[8*i +: 8] = acc_be[i] ? acc_wdata[8*i +: 8] : mem_rword[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      err_d = acc_err;
      if (acc_err)        rdata_d = ERR_CODE;
      else if (acc_write) rdata_d = '0;
      else                rdata_d = mem_rword;
    end
  end

  assign mem_we = enter_resp && acc_write && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has two wait states,
// instance 1 has none; both share clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(100), .WAIT_CYCLES(2), .ERR_CODE(32'h0000DEAD)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(100), .WAIT_CYCLES(0), .ERR_CODE(32'h0000DEAD)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // One full transaction with rsp_ready=1; returns what was observed.
  // lat counts edges after the accept edge until rsp_valid is sampled high.
  task automatic run_txn(input int u, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic rdy_after);
    @(negedge clk);
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a;
    req_wdata[u] = wd; req_be[u] = be; rsp_ready[u] = 1'b1;
    @(negedge clk);
    req_valid[u] = 1'b0; req_addr[u] = 32'hFFFF_FFFF; req_wdata[u] = 32'h0BAD_0BAD; req_be[u] = 4'h0;
    lat = 1;
    while (!rsp_valid[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[u];
    er = rsp_err[u];
    @(negedge clk);
    rdy_after = req_ready[u] && !rsp_valid[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0; req_be[u] = '0; rsp_ready[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready[0] !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready[0]); else passes++;
    checks++; if (rsp_valid[0] !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid[0]); else passes++;
    checks++; if (rsp_rdata[0] !== 32'h0) $display("FAIL reset_rsp_rdata: got %h want 00000000", rsp_rdata[0]); else passes++;
    checks++; if (rsp_err[0] !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err[0]); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready[0] !== 1'b1) $display("FAIL release_req_ready_a: got %b want 1", req_ready[0]); else passes++;
    checks++; if (req_ready[1] !== 1'b1) $display("FAIL release_req_ready_b: got %b want 1", req_ready[1]); else passes++;
  endtask

  task automatic test_load_zero();
    logic [31:0] rd; logic er, ra; int lat;
    run_txn(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (lat !== 3) $display("FAIL load0_latency: got %0d want 3", lat); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL load0_rdata: got %h want 00000000", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL load0_err: got %b want 0", er); else passes++;
    checks++; if (ra !== 1'b1) $display("FAIL load0_idle_after: got %b want 1", ra); else passes++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er, ra; int lat;
    run_txn(0, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL store_full_rsp: got %h/%b want 00000000/0", rd, er); else passes++;
    checks++; if (lat !== 3) $display("FAIL store_full_latency: got %0d want 3", lat); else passes++;
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra);
    checks++; if (rd !== 32'hCAFEBABE) $display("FAIL load_full: got %h want cafebabe", rd); else passes++;
    run_txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat, ra);
    checks++; if (er !== 1'b0) $display("FAIL store_lane0_err: got %b want 0", er); else passes++;
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra);
    checks++; if (rd !== 32'hCAFEBAAA) $display("FAIL load_lane0: got %h want cafebaaa", rd); else passes++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, ra; int lat;
    run_txn(0, 1'b0, 32'h190, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h0000DEAD || er !== 1'b1) $display("FAIL load_oob: got %h/%b want 0000dead/1", rd, er); else passes++;
    run_txn(0, 1'b0, 32'h2, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h0000DEAD || er !== 1'b1) $display("FAIL load_misaligned: got %h/%b want 0000dead/1", rd, er); else passes++;
    run_txn(0, 1'b1, 32'h190, 32'hFFFFFFFF, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h0000DEAD || er !== 1'b1) $display("FAIL store_oob: got %h/%b want 0000dead/1", rd, er); else passes++;
    run_txn(0, 1'b0, 32'h18C, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL last_word_intact: got %h/%b want 00000000/0", rd, er); else passes++;
    run_txn(0, 1'b1, 32'h4000_0010, 32'h11111111, 4'hF, rd, er, lat, ra);
    checks++; if (er !== 1'b1) $display("FAIL store_high_addr_err: got %b want 1", er); else passes++;
    run_txn(0, 1'b1, 32'h10, 32'h22222222, 4'h0, rd, er, lat, ra);
    checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL store_be0_rsp: got %h/%b want 00000000/0", rd, er); else passes++;
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra);
    checks++; if (rd !== 32'hCAFEBAAA) $display("FAIL no_wrap_no_write: got %h want cafebaaa", rd); else passes++;
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0; rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_addr[0] = 32'h190;
    n = 1;
    while (!rsp_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 3) $display("FAIL bp_latency: got %0d want 3", n); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid[0] !== 1'b1) $display("FAIL bp_valid_hold[%0d]: got %b want 1", k, rsp_valid[0]); else passes++;
      checks++; if (rsp_rdata[0] !== 32'hCAFEBAAA) $display("FAIL bp_rdata_hold[%0d]: got %h want cafebaaa", k, rsp_rdata[0]); else passes++;
      checks++; if (rsp_err[0] !== 1'b0) $display("FAIL bp_err_hold[%0d]: got %b want 0", k, rsp_err[0]); else passes++;
      checks++; if (req_ready[0] !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", k, req_ready[0]); else passes++;
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid[0] !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", rsp_valid[0]); else passes++;
    checks++; if (req_ready[0] !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req_ready[0]); else passes++;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er, ra; int lat;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h12345678; req_be[0] = 4'hF; rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid[0] !== 1'b0) $display("FAIL rstwait_valid: got %b want 0", rsp_valid[0]); else passes++;
    checks++; if (req_ready[0] !== 1'b0) $display("FAIL rstwait_ready: got %b want 0", req_ready[0]); else passes++;
    checks++; if (rsp_rdata[0] !== 32'h0) $display("FAIL rstwait_rdata: got %h want 00000000", rsp_rdata[0]); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL rstwait_not_committed: got %h/%b want 00000000/0", rd, er); else passes++;
    checks++; if (lat !== 3) $display("FAIL rstwait_next_latency: got %0d want 3", lat); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, ra; int lat, vcnt, bad;
    run_txn(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (lat !== 1) $display("FAIL w0_load_latency: got %0d want 1", lat); else passes++;
    checks++; if (ra !== 1'b1) $display("FAIL w0_idle_after: got %b want 1", ra); else passes++;
    run_txn(1, 1'b1, 32'h4, 32'h00000055, 4'hF, rd, er, lat, ra);
    checks++; if (lat !== 1 || er !== 1'b0) $display("FAIL w0_store: got lat %0d err %b want 1/0", lat, er); else passes++;
    run_txn(1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, lat, ra);
    checks++; if (rd !== 32'h00000055) $display("FAIL w0_load: got %h want 00000055", rd); else passes++;
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h4; rsp_ready[1] = 1'b1;
    vcnt = 0;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) vcnt++;
      if (rsp_valid[1] !== 1'((k % 2) == 1)) bad++;
      if (rsp_valid[1] && rsp_rdata[1] !== 32'h00000055) bad++;
    end
    req_valid[1] = 1'b0;
    checks++; if (vcnt !== 5) $display("FAIL b2b_count: got %0d want 5", vcnt); else passes++;
    checks++; if (bad !== 0) $display("FAIL b2b_pattern: got %0d bad samples want 0", bad); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_zero();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory port. It accepts one load/store request at a time over a valid/ready handshake.
- It services each request after a programmable number of wait states. It returns read data, or an error code for bad addresses, over a separate valid/ready response channel.
- It replaces the processor's direct, combinational data-memory connection. The core must now stall on handshakes instead of assuming single-cycle memory.

Parameters:
DEPTH, 100, number of 32-bit words in the array
WAIT_CYCLES, 2, extra cycles between request accept and response valid (0..15)
ERR_CODE, 32'h0000DEAD, read data returned on an errored access

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables, bit i covers wdata[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load data; 0 for stores; ERR_CODE on error
rsp_err  out  1  access rejected

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE. req_ready=0 while rst_n is low and 1 on the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, captured request registers=0.
  - The memory array is not reset. It is initialised to all zeros at time 0 only.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A request is accepted on the edge where req_valid & req_ready.
    - On accept, capture write, addr, wdata and be.
    - Go to RESP if WAIT_CYCLES==0, else go to WAIT with the counter loaded to WAIT_CYCLES-1.
  - WAIT: req_ready=0. The counter decrements each cycle. When it is 0, go to RESP at the next edge.
  - RESP: req_ready=0, rsp_valid=1.
    - Outputs hold stable until the rsp_valid & rsp_ready edge, then go to IDLE.
    - rsp_valid drops in the same edge.
- Memory access happens on the edge that enters RESP:
  - Store: writes are committed on that edge.
  - Load: rsp_rdata is registered on that edge.
- Latency: accept at edge E0 gives rsp_valid high at edge E0+WAIT_CYCLES+1.
- Only one request is outstanding at a time. At least one IDLE cycle separates a response handshake from the next accept.
- Address decode:
  - Word index = req_addr[31:2].
  - Error if req_addr[1:0]!=0 (misaligned) or index>=DEPTH.
  - On error: no array write, rsp_rdata=ERR_CODE, rsp_err=1, for both loads and stores.
- Store: only lanes with be[i]=1 are updated. be=4'b0000 is a legal no-op with rsp_err=0. rsp_rdata=0.
- Load: be is ignored and the full word is returned.
- Address and data are sampled only at accept. Changes to req_* after accept have no effect.
- Reset mid-operation:
  - Reset in WAIT abandons the request. A store is not committed.
  - Reset in RESP abandons the response. A store already committed stays in the array.
- rsp_ready is ignored outside RESP. req_valid is ignored outside IDLE.
- Index arithmetic is unsigned. Addresses at or above 4*DEPTH are errors and never wrap into the array.

Test Plan:
- Reset then load from addr 0x00, rsp_ready=1, WAIT_CYCLES=2: accept at E0 -> rsp_valid at E0+3, rsp_rdata=0x00000000, rsp_err=0, req_ready=1 at E0+4.
- Store 0xCAFEBABE to 0x10 with be=4'hF, then load 0x10 -> load returns 0xCAFEBABE. Then store 0x000000AA with be=4'b0001 and load -> returns 0xCAFEBAAA.
- Load 0x190 (index 100) and load 0x02 (misaligned) -> each returns rsp_err=1, rsp_rdata=0x0000DEAD. A store to 0x190 must not alter word 99 (verify by a load of 0x18C).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable, and req_ready stays 0 even with req_valid=1. Release -> response completes and IDLE follows.
- Reset during WAIT of a store of 0x12345678 to 0x20 -> all outputs are reset immediately. A subsequent load of 0x20 returns the prior value 0x00000000.
- WAIT_CYCLES=0 instance: accept at E0 -> rsp_valid at E0+1. Back-to-back requests with req_valid held high complete one per 2 cycles with rsp_ready=1.
